// File: rtl/aes_ctr_engine_if.sv
// Handshake and control bundle between the AES-CTR engine and its stream/key-schedule neighbours.
// The round-key bus width follows the key length.
interface aes_ctr_engine_if #(
  parameter int unsigned KEY_BITS = 256
);
  localparam int unsigned NR = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;
  localparam int unsigned RK_W = (NR + 1) * 128;

  logic            iv_load;
  logic [127:0]    iv_i;
  logic [RK_W-1:0] rkeys_i;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_data;
  logic [127:0]    ctr_o;
  logic            ctr_wrap;
  logic            busy;

  modport master (
    output iv_load, iv_i, rkeys_i, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ctr_o, ctr_wrap, busy
  );

  modport slave (
    input  iv_load, iv_i, rkeys_i, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ctr_o, ctr_wrap, busy
  );
endinterface

// File: rtl/aes_ctr_engine.sv
// Iterative AES-128/192/256 CTR engine: one round per clock on the counter block,
// keystream XORed with the input block, low counter field auto-incremented per block.
module aes_ctr_engine #(
  parameter int unsigned KEY_BITS = 256,
  parameter int unsigned CTR_BITS = 32
) (
  input logic           clk,
  input logic           rst,
  aes_ctr_engine_if.slave bus
);
  localparam int unsigned NR = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_BITS);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
    $error("aes_ctr_engine: KEY_BITS must be 128, 192 or 256");
  end
  if (CTR_BITS < 8 || CTR_BITS > 128) begin : g_bad_ctr
    $error("aes_ctr_engine: CTR_BITS must be in 8..128");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_HOLD} state_e;

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Round keys padded to 16 entries so the 4-bit round index is always in range.
  logic [127:0] rk [16];
  for (genvar r = 0; r < 16; r++) begin : g_rk
    if (r <= NR) begin : g_used
      assign rk[r] = bus.rkeys_i[128*r +: 128];
    end else begin : g_pad
      assign rk[r] = '0;
    end
  end

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dat_q, dat_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] ctr_q, ctr_d;
  logic         wrap_q, wrap_d;

  logic         in_ready_c;
  logic         accept_c;
  logic [127:0] sr_c;
  logic [127:0] ctr_low_c;

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    st_d        = st_q;
    dat_d       = dat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ctr_d       = ctr_q;
    wrap_d      = wrap_q;

    in_ready_c = !bus.iv_load && (state_q == S_IDLE || (state_q == S_HOLD && bus.out_ready));
    accept_c   = bus.in_valid && in_ready_c;
    sr_c       = shift_rows(sub_bytes(st_q));
    ctr_low_c  = (ctr_q + 128'd1) & CTR_MASK;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iv_load) begin
          ctr_d  = bus.iv_i;
          wrap_d = 1'b0;
        end
      end
      S_ROUND: begin
        if (round_q != 4'(NR)) begin
          st_d    = mix_columns(sr_c) ^ rk[round_q];
          round_d = 4'(round_q + 4'd1);
        end else begin
          out_data_d  = sr_c ^ rk[NR] ^ dat_q;
          out_valid_d = 1'b1;
          ctr_d       = (ctr_q & ~CTR_MASK) | ctr_low_c;
          if (ctr_low_c == '0) wrap_d = 1'b1;
          round_d     = 4'd0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new block may start from IDLE or straight out of HOLD.
    if (accept_c) begin
      st_d    = ctr_q ^ rk[0];
      dat_d   = bus.in_data;
      round_d = 4'd1;
      state_d = S_ROUND;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_q     <= 4'd0;
      st_q        <= '0;
      dat_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ctr_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      st_q        <= st_d;
      dat_q       <= dat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ctr_q       <= ctr_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ctr_o     = ctr_q;
  assign bus.ctr_wrap  = wrap_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_aes_ctr_engine.sv
// Bench for aes_ctr_engine: FIPS-197 vectors, a randomized vector table scored against a
// byte-level AES/CTR model, and hand-written stall, reset and load-collision sequences.
module tb_aes_ctr_engine;
  typedef logic [127:0] rk_arr_t [15];
  typedef struct {
    logic         do_load;
    logic [127:0] iv;
    logic [127:0] data;
    logic [127:0] exp_out;
    logic [127:0] exp_ctr;
    logic         exp_wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_ctr_engine_if #(.KEY_BITS(256)) bus256 ();
  aes_ctr_engine_if #(.KEY_BITS(128)) bus128 ();

  aes_ctr_engine #(.KEY_BITS(256), .CTR_BITS(32)) dut256 (.clk(clk), .rst(rst), .bus(bus256.slave));
  aes_ctr_engine #(.KEY_BITS(128), .CTR_BITS(8))  dut128 (.clk(clk), .rst(rst), .bus(bus128.slave));

  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   sb [256];
  rk_arr_t      rk256, rk128;
  logic [127:0] model_ctr;
  logic         model_wrap;
  vec_t         vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} >> (8 - n);
    return t[7:0];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic key_expand(input logic [255:0] key, input int nk, output rk_arr_t rks);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subword(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r < 15; r++)
      rks[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] blk, input rk_arr_t rks, input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = blk[127-8*(4*c+r) -: 8] ^ rks[0][127-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd != nr)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ rks[rd][127-8*(4*c+r) -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // CTR scoreboard: keystream from the current counter, then bump the low 32-bit field.
  task automatic model_block(input logic [127:0] d, output logic [127:0] exp);
    exp = ref_encrypt(model_ctr, rk256, 14) ^ d;
    model_ctr[31:0] = model_ctr[31:0] + 32'd1;
    if (model_ctr[31:0] == 32'd0) model_wrap = 1'b1;
  endtask

  task automatic load256(input logic [127:0] iv);
    bus256.iv_load = 1'b1;
    bus256.iv_i    = iv;
    @(negedge clk);
    bus256.iv_load = 1'b0;
    chk("iv_load_ctr", bus256.ctr_o, iv);
    chk("iv_load_wrap", 128'(bus256.ctr_wrap), 128'd0);
  endtask

  task automatic start256(input logic [127:0] d);
    bus256.in_valid = 1'b1;
    bus256.in_data  = d;
    #1;
    chk("in_ready_idle", 128'(bus256.in_ready), 128'd1);
    @(negedge clk);
    bus256.in_valid = 1'b0;
  endtask

  task automatic wait_out256(output int lat);
    lat = 0;
    while (!bus256.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain256();
    bus256.out_ready = 1'b1;
    @(negedge clk);
    bus256.out_ready = 1'b0;
    chk("drain_out_valid", 128'(bus256.out_valid), 128'd0);
    chk("drain_busy", 128'(bus256.busy), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat;
    int           seen;
    logic [127:0] exp_a, exp_b, dat_a, dat_b, iv_x;

    build_sbox();
    key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, rk256);
    key_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, rk128);
    for (int r = 0; r <= 14; r++) bus256.rkeys_i[128*r +: 128] = rk256[r];
    for (int r = 0; r <= 10; r++) bus128.rkeys_i[128*r +: 128] = rk128[r];
    {bus256.iv_load, bus256.in_valid, bus256.out_ready} = 3'b000;
    {bus128.iv_load, bus128.in_valid, bus128.out_ready} = 3'b000;
    bus256.iv_i = '0; bus256.in_data = '0;
    bus128.iv_i = '0; bus128.in_data = '0;

    // Vector table: FIPS-197 C.3 first, then a wrap row, a sticky row and random rows.
    vecs[0] = '{1'b1, 128'h00112233445566778899aabbccddeeff, 128'h0,
                128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddef00, 1'b0};
    model_ctr  = vecs[0].iv;
    model_wrap = 1'b0;
    model_block(vecs[0].data, exp_a);
    for (int i = 1; i < 8; i++) begin
      vecs[i].do_load = (i == 2 || i == 4 || i == 6);
      vecs[i].iv      = rand128();
      if (i == 2) vecs[i].iv[31:0] = 32'hffffffff;
      if (i == 4) vecs[i].iv[31:0] = 32'hfffffff0;
      vecs[i].data = rand128();
      if (vecs[i].do_load) begin
        model_ctr  = vecs[i].iv;
        model_wrap = 1'b0;
      end
      model_block(vecs[i].data, vecs[i].exp_out);
      vecs[i].exp_ctr  = model_ctr;
      vecs[i].exp_wrap = model_wrap;
    end

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(bus256.out_valid), 128'd0);
    chk("rst_out_data", bus256.out_data, 128'h0);
    chk("rst_ctr", bus256.ctr_o, 128'h0);
    chk("rst_wrap", 128'(bus256.ctr_wrap), 128'd0);
    chk("rst_busy", 128'(bus256.busy), 128'd0);
    rst = 1'b1;
    @(negedge clk);

    // AES-128 FIPS-197 C.1 with an 8-bit counter field that wraps on this block.
    bus128.iv_load = 1'b1;
    bus128.iv_i    = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    bus128.iv_load  = 1'b0;
    bus128.in_valid = 1'b1;
    bus128.in_data  = 128'h0;
    #1;
    chk("a128_in_ready", 128'(bus128.in_ready), 128'd1);
    @(negedge clk);
    bus128.in_valid = 1'b0;
    lat = 0;
    while (!bus128.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("a128_latency", 128'(lat), 128'd10);
    chk("a128_out", bus128.out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("a128_ctr", bus128.ctr_o, 128'h00112233445566778899aabbccddee00);
    chk("a128_wrap", 128'(bus128.ctr_wrap), 128'd1);
    bus128.out_ready = 1'b1;
    @(negedge clk);
    bus128.out_ready = 1'b0;
    chk("a128_idle", 128'(bus128.busy), 128'd0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_load) load256(vecs[i].iv);
      start256(vecs[i].data);
      wait_out256(lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd14);
      chk($sformatf("vec%0d_out", i), bus256.out_data, vecs[i].exp_out);
      chk($sformatf("vec%0d_ctr", i), bus256.ctr_o, vecs[i].exp_ctr);
      chk($sformatf("vec%0d_wrap", i), 128'(bus256.ctr_wrap), 128'(vecs[i].exp_wrap));
      drain256();
    end

    // iv_load and in_valid together in IDLE: the load wins, nothing starts.
    iv_x = rand128();
    bus256.iv_load  = 1'b1;
    bus256.iv_i     = iv_x;
    bus256.in_valid = 1'b1;
    bus256.in_data  = rand128();
    #1;
    chk("collide_in_ready", 128'(bus256.in_ready), 128'd0);
    @(negedge clk);
    bus256.iv_load  = 1'b0;
    bus256.in_valid = 1'b0;
    chk("collide_busy", 128'(bus256.busy), 128'd0);
    chk("collide_ctr", bus256.ctr_o, iv_x);
    chk("collide_wrap", 128'(bus256.ctr_wrap), 128'd0);
    model_ctr  = iv_x;
    model_wrap = 1'b0;

    // Stall in HOLD for five cycles, then release with a new block accepted the same cycle.
    dat_a = rand128();
    dat_b = rand128();
    model_block(dat_a, exp_a);
    start256(dat_a);
    wait_out256(lat);
    chk("stall_a_latency", 128'(lat), 128'd14);
    bus256.in_valid = 1'b1;
    bus256.in_data  = dat_b;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", 128'(bus256.in_ready), 128'd0);
      chk("stall_out_data", bus256.out_data, exp_a);
      chk("stall_out_valid", 128'(bus256.out_valid), 128'd1);
      @(negedge clk);
    end
    bus256.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 128'(bus256.in_ready), 128'd1);
    model_block(dat_b, exp_b);
    @(negedge clk);
    bus256.in_valid  = 1'b0;
    bus256.out_ready = 1'b0;
    chk("b2b_out_valid", 128'(bus256.out_valid), 128'd0);
    chk("b2b_busy", 128'(bus256.busy), 128'd1);
    wait_out256(lat);
    chk("b2b_latency", 128'(lat), 128'd14);
    chk("b2b_out", bus256.out_data, exp_b);
    chk("b2b_ctr", bus256.ctr_o, model_ctr);
    drain256();

    // Reset while round 7 is in flight: block discarded, then a fresh block runs cleanly.
    start256(rand128());
    repeat (6) @(negedge clk);
    chk("mid_busy", 128'(bus256.busy), 128'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus256.out_valid), 128'd0);
    chk("mid_rst_ctr", bus256.ctr_o, 128'h0);
    chk("mid_rst_busy", 128'(bus256.busy), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    model_ctr  = '0;
    model_wrap = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus256.out_valid) seen++;
    end
    chk("mid_rst_no_output", 128'(seen), 128'd0);
    iv_x  = rand128();
    dat_a = rand128();
    load256(iv_x);
    model_ctr = iv_x;
    model_block(dat_a, exp_a);
    start256(dat_a);
    wait_out256(lat);
    chk("post_rst_latency", 128'(lat), 128'd14);
    chk("post_rst_out", bus256.out_data, exp_a);
    chk("post_rst_ctr", bus256.ctr_o, model_ctr);
    drain256();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
